// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and sizes for the SPI slave (spi_slave, spi_tx_serializer).
//   state_t   : protocol FSM states
//   RX_W      : width of the parallel word sent to the RAM ({cmd[1:0], byte})
//   TX_W      : width of the read byte returned by the RAM
//   CNT_W     : width of the receive bit counter (counts 0..RX_W-1)
//   TX_CNT_W  : width of the transmit bit counter (counts 0..TX_W-1)
// ---------------------------------------------------------------------------
package spi_pkg;

   localparam int RX_W     = 10;
   localparam int TX_W     = 8;
   localparam int CNT_W    = 4;
   localparam int TX_CNT_W = 3;

   localparam logic [CNT_W-1:0]    RX_LAST_BIT = CNT_W'(RX_W - 1);
   localparam logic [TX_CNT_W-1:0] TX_LAST_BIT = TX_CNT_W'(TX_W - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

endpackage

// File: rtl/spi_tx_serializer.sv
// ---------------------------------------------------------------------------
// spi_tx_serializer
// Captures the RAM read byte and shifts it out MSB first, one bit per clock.
// The output is forced low whenever no byte is being shifted.
// Ports:
//   clk      in   bit clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears the captured byte)
//   i_load   in   capture i_data this cycle and start shifting
//   i_abort  in   stop shifting immediately (frame ended)
//   i_data   in   [TX_W-1:0] byte to serialize
//   o_miso   out  serial bit, 0 when idle
//   o_busy   out  high while bits are being presented on o_miso
// ---------------------------------------------------------------------------
module spi_tx_serializer
   import spi_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic            i_abort,
   input  logic [TX_W-1:0] i_data,
   output logic            o_miso,
   output logic            o_busy
);

   logic [TX_W-1:0]     r_shift;
   logic [TX_CNT_W-1:0] r_cnt;
   logic                r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else if (i_abort) begin
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else if (i_load) begin
         r_shift <= i_data;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else if (r_busy) begin
         // bit 7 is shown in the cycle after the load; each edge moves on
         // by one bit, and the edge after bit 0 has been shown ends the byte
         r_shift <= {r_shift[TX_W-2:0], 1'b0};
         r_cnt   <= r_cnt + 1'b1;
         if (r_cnt == TX_LAST_BIT) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_miso = r_busy & r_shift[TX_W-1];
   assign o_busy = r_busy;

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI slave front end for a single-port RAM. A frame (SS_n low) carries a
// select bit followed by a 10-bit word {cmd[1:0], addr/data[7:0]}, MSB first.
// The word is presented on rx_data with a one-cycle rx_valid strobe. For a
// read-data frame the byte returned by the RAM (tx_valid/tx_data) is shifted
// back on MISO, MSB first.
//
// Handshake: rx_valid is a one-cycle strobe with no back-pressure; rx_data
// holds until the next completed word. tx_valid is a one-cycle strobe that
// is accepted only while a read-data frame is waiting for its byte; at any
// other time it is ignored.
//
// Build option SPI_RD_ORDER_EN:
//   defined   - a select bit of 1 alternates between READ_ADD and READ_DATA
//               using the internal rd_addr_done flag.
//   undefined - no rd_addr_done; select bit 1 always enters READ_DATA, and the
//               byte is returned only when the received command is 2'b11.
//
// Ports:
//   clk          in   bit clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   SS_n         in   slave select, active low
//   MOSI         in   serial data in
//   MISO         out  serial data out, 0 when not serializing
//   rx_data      out  [9:0] received word to the RAM
//   rx_valid     out  one-cycle strobe, rx_data valid
//   tx_data      in   [7:0] read byte from the RAM
//   tx_valid     in   tx_data valid strobe
//   o_dbg_state  out  current FSM state (debug observation)
// ---------------------------------------------------------------------------
module spi_slave
   import spi_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            SS_n,
   input  logic            MOSI,
   output logic            MISO,
   output logic [RX_W-1:0] rx_data,
   output logic            rx_valid,
   input  logic [TX_W-1:0] tx_data,
   input  logic            tx_valid,
   output state_t          o_dbg_state
);

   state_t           r_state;
   state_t           w_next_state;
   logic             r_armed;      // SS_n seen high since reset
   logic [CNT_W-1:0] r_cnt;
   logic [RX_W-2:0]  r_shift;      // first nine bits of the word in flight
   logic [RX_W-1:0]  r_rx_data;
   logic             r_rx_valid;
   logic             r_rx_done;    // all ten bits of this frame received
   logic             r_tx_loaded;  // this frame's read byte already taken
   logic             w_shift_en;
   logic             w_tx_load;
   logic             w_cmd_ok;
   logic             w_tx_busy;
`ifdef SPI_RD_ORDER_EN
   logic             r_rd_addr_done;
`endif

`ifdef SPI_RD_ORDER_EN
   assign w_cmd_ok = 1'b1;
`else
   assign w_cmd_ok = (r_rx_data[RX_W-1:RX_W-2] == 2'b11);
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next state and per-cycle controls
   always_comb begin
      w_next_state = r_state;
      w_shift_en   = 1'b0;
      w_tx_load    = 1'b0;
      if (SS_n) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               // after reset a frame only starts once SS_n has been high
               if (r_armed) w_next_state = CHK_CMD;
            end
            CHK_CMD: begin
               if (!MOSI) begin
                  w_next_state = WRITE;
               end else begin
`ifdef SPI_RD_ORDER_EN
                  w_next_state = r_rd_addr_done ? READ_DATA : READ_ADD;
`else
                  w_next_state = READ_DATA;
`endif
               end
            end
            WRITE, READ_ADD: begin
               w_shift_en = !r_rx_done;
            end
            READ_DATA: begin
               w_shift_en = !r_rx_done;
               w_tx_load  = r_rx_done && !r_tx_loaded && !w_tx_busy &&
                            tx_valid && w_cmd_ok;
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   // receive datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed     <= 1'b0;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_rx_done   <= 1'b0;
         r_tx_loaded <= 1'b0;
`ifdef SPI_RD_ORDER_EN
         r_rd_addr_done <= 1'b0;
`endif
      end else begin
         r_rx_valid <= 1'b0;
         if (SS_n) begin
            // frame over or aborted: drop any partial word
            r_armed     <= 1'b1;
            r_cnt       <= '0;
            r_rx_done   <= 1'b0;
            r_tx_loaded <= 1'b0;
         end else begin
            if (w_shift_en) begin
               if (r_cnt == RX_LAST_BIT) begin
                  // rx_data only changes on a complete word
                  r_rx_data  <= {r_shift, MOSI};
                  r_rx_valid <= 1'b1;
                  r_rx_done  <= 1'b1;
                  r_cnt      <= '0;
`ifdef SPI_RD_ORDER_EN
                  if (r_state == READ_ADD) begin
                     r_rd_addr_done <= 1'b1;
                  end else if (r_state == READ_DATA) begin
                     r_rd_addr_done <= 1'b0;
                  end
`endif
               end else begin
                  r_shift <= {r_shift[RX_W-3:0], MOSI};
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            if (w_tx_load) begin
               r_tx_loaded <= 1'b1;
            end
         end
      end
   end

   spi_tx_serializer u_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_tx_load),
      .i_abort (SS_n),
      .i_data  (tx_data),
      .o_miso  (MISO),
      .o_busy  (w_tx_busy)
   );

   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
// Directed bench for spi_slave. Inputs change on the falling clock edge and
// outputs are checked there too, half a cycle after the rising edge that
// updates them. Works with or without SPI_RD_ORDER_EN.
// ---------------------------------------------------------------------------
module tb_spi_slave;
   import spi_pkg::*;

   logic            clk;
   logic            rst_n;
   logic            SS_n;
   logic            MOSI;
   logic            MISO;
   logic [RX_W-1:0] rx_data;
   logic            rx_valid;
   logic [TX_W-1:0] tx_data;
   logic            tx_valid;
   state_t          dbg_state;

   int n_vec = 0;
   int n_err = 0;

`ifdef SPI_RD_ORDER_EN
   localparam state_t FIRST_RD_STATE = READ_ADD;
`else
   localparam state_t FIRST_RD_STATE = READ_DATA;
`endif

   spi_slave dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .SS_n        (SS_n),
      .MOSI        (MOSI),
      .MISO        (MISO),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   // driver tasks (called at a falling edge, return at the next falling edge)
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      MOSI = b;
      cycle();
   endtask

   task automatic start_frame(input logic sel);
      SS_n = 1'b0;
      cycle();
      send_bit(sel);
   endtask

   task automatic send_range(input logic [RX_W-1:0] w, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) send_bit(w[i]);
   endtask

   task automatic end_frame();
      SS_n = 1'b1;
      MOSI = 1'b0;
      cycle();
   endtask

   // tests
   task automatic test_reset();
      rst_n = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rst_miso: got %b want 0", MISO); end
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
      n_vec++; if (rx_data !== 10'h000) begin n_err++; $display("FAIL rst_rx_data: got %h want 000", rx_data); end
      n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
      rst_n = 1'b1;
      cycle();
      cycle();
   endtask

   task automatic test_write_addr();
      start_frame(1'b0);
      send_range(10'h005, 9, 1);
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL wa_early_valid: got %b want 0", rx_valid); end
      n_vec++; if (dbg_state !== WRITE) begin n_err++; $display("FAIL wa_state: got %0d want %0d", dbg_state, WRITE); end
      send_bit(1'b1);
      n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL wa_valid: got %b want 1", rx_valid); end
      n_vec++; if (rx_data !== 10'h005) begin n_err++; $display("FAIL wa_data: got %h want 005", rx_data); end
      cycle();
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL wa_valid_one_cycle: got %b want 0", rx_valid); end
      n_vec++; if (rx_data !== 10'h005) begin n_err++; $display("FAIL wa_data_hold: got %h want 005", rx_data); end
      end_frame();
      n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL wa_end_state: got %0d want %0d", dbg_state, IDLE); end
   endtask

   task automatic test_write_data();
      start_frame(1'b0);
      send_range(10'h1AA, 9, 0);
      n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL wd_valid: got %b want 1", rx_valid); end
      n_vec++; if (rx_data !== 10'h1AA) begin n_err++; $display("FAIL wd_data: got %h want 1aa", rx_data); end
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL wd_miso: got %b want 0", MISO); end
      cycle();
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL wd_valid_one_cycle: got %b want 0", rx_valid); end
      end_frame();
   endtask

   task automatic test_read_seq();
      logic [TX_W-1:0] exp_byte;
      exp_byte = 8'hC3;
      // address frame: a stray tx_valid here must not produce MISO activity
      start_frame(1'b1);
      n_vec++; if (dbg_state !== FIRST_RD_STATE) begin n_err++; $display("FAIL rd_addr_state: got %0d want %0d", dbg_state, FIRST_RD_STATE); end
      send_range(10'h205, 9, 0);
      n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL rd_addr_valid: got %b want 1", rx_valid); end
      n_vec++; if (rx_data !== 10'h205) begin n_err++; $display("FAIL rd_addr_data: got %h want 205", rx_data); end
      tx_data = 8'hFF; tx_valid = 1'b1;
      cycle();
      tx_valid = 1'b0;
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rd_addr_miso: got %b want 0", MISO); end
      cycle();
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rd_addr_miso2: got %b want 0", MISO); end
      end_frame();
      // data frame
      start_frame(1'b1);
      n_vec++; if (dbg_state !== READ_DATA) begin n_err++; $display("FAIL rd_data_state: got %0d want %0d", dbg_state, READ_DATA); end
      send_range(10'h300, 9, 0);
      n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL rd_data_valid: got %b want 1", rx_valid); end
      n_vec++; if (rx_data !== 10'h300) begin n_err++; $display("FAIL rd_data_data: got %h want 300", rx_data); end
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rd_pre_miso: got %b want 0", MISO); end
      tx_data = exp_byte; tx_valid = 1'b1;
      cycle();
      tx_valid = 1'b0; tx_data = '0;
      for (int i = 0; i < TX_W; i++) begin
         n_vec++; if (MISO !== exp_byte[TX_W-1-i]) begin n_err++; $display("FAIL rd_miso_bit%0d: got %b want %b", TX_W-1-i, MISO, exp_byte[TX_W-1-i]); end
         cycle();
      end
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rd_post_miso: got %b want 0", MISO); end
      tx_data = 8'hFF; tx_valid = 1'b1;
      cycle();
      tx_valid = 1'b0;
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rd_second_tx_ignored: got %b want 0", MISO); end
      end_frame();
      // rd_addr_done is cleared again, so a read frame starts as before
      start_frame(1'b1);
      n_vec++; if (dbg_state !== FIRST_RD_STATE) begin n_err++; $display("FAIL rd_next_state: got %0d want %0d", dbg_state, FIRST_RD_STATE); end
      end_frame();
   endtask

   task automatic test_abort();
      start_frame(1'b0);
      send_range(10'h0FF, 9, 5);
      SS_n = 1'b1;
      cycle();
      n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL abort_state: got %0d want %0d", dbg_state, IDLE); end
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b want 0", rx_valid); end
      n_vec++; if (rx_data !== 10'h300) begin n_err++; $display("FAIL abort_data: got %h want 300", rx_data); end
      cycle();
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid2: got %b want 0", rx_valid); end
   endtask

   task automatic test_tx_in_write();
      logic [RX_W-1:0] w;
      w = 10'h2C3;
      start_frame(1'b0);
      send_range(w, 9, 6);
      tx_data = 8'hA5; tx_valid = 1'b1;
      send_bit(w[5]);
      tx_valid = 1'b0;
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL txw_mid_miso: got %b want 0", MISO); end
      send_range(w, 4, 0);
      n_vec++; if (rx_data !== 10'h2C3) begin n_err++; $display("FAIL txw_data: got %h want 2c3", rx_data); end
      tx_valid = 1'b1;
      cycle();
      tx_valid = 1'b0;
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL txw_post_miso: got %b want 0", MISO); end
      cycle();
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL txw_post_miso2: got %b want 0", MISO); end
      end_frame();
   endtask

   task automatic test_back_to_back();
      start_frame(1'b0);
      send_range(10'h0F0, 9, 0);
      n_vec++; if (rx_data !== 10'h0F0) begin n_err++; $display("FAIL b2b_data1: got %h want 0f0", rx_data); end
      SS_n = 1'b1;
      cycle();
      n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL b2b_gap_state: got %0d want %0d", dbg_state, IDLE); end
      start_frame(1'b0);
      send_range(10'h30F, 9, 0);
      n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid2: got %b want 1", rx_valid); end
      n_vec++; if (rx_data !== 10'h30F) begin n_err++; $display("FAIL b2b_data2: got %h want 30f", rx_data); end
      end_frame();
   endtask

   task automatic test_async_reset();
      start_frame(1'b1);
      send_range(10'h205, 9, 0);
      end_frame();
      start_frame(1'b1);
      send_range(10'h311, 9, 0);
      tx_data = 8'hC3; tx_valid = 1'b1;
      cycle();
      tx_valid = 1'b0;
      n_vec++; if (MISO !== 1'b1) begin n_err++; $display("FAIL ar_miso_active: got %b want 1", MISO); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL ar_miso: got %b want 0", MISO); end
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b want 0", rx_valid); end
      n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL ar_state: got %0d want %0d", dbg_state, IDLE); end
      n_vec++; if (rx_data !== 10'h000) begin n_err++; $display("FAIL ar_data: got %h want 000", rx_data); end
      // release with SS_n still low: no frame until SS_n goes high first
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      cycle();
      n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL ar_no_resume: got %0d want %0d", dbg_state, IDLE); end
      end_frame();
      start_frame(1'b0);
      send_range(10'h155, 9, 0);
      n_vec++; if (rx_data !== 10'h155) begin n_err++; $display("FAIL ar_recover_data: got %h want 155", rx_data); end
      end_frame();
   endtask

   // sequence and final report
   initial begin
      test_reset();
      test_write_addr();
      test_write_data();
      test_read_seq();
      test_abort();
      test_tx_in_write();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset inputs.
REQ-002 clk  input  1  serial bit clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 SS_n  input  1  slave select, active low; frame spans SS_n low.
REQ-005 MOSI  input  1  serial data in, MSB first.
REQ-006 MISO  output  1  serial data out, MSB first.
REQ-007 rx_data  output  10  parallel word to RAM: [9:8] command, [7:0] address/data.
REQ-008 rx_valid  output  1  one-cycle strobe, rx_data valid.
REQ-009 tx_data  input  8  read data from RAM.
REQ-010 tx_valid  input  1  tx_data valid strobe from RAM.

Function
REQ-011 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE -> CHK_CMD when SS_n=0, else stay.
REQ-013 In CHK_CMD, the sampled MOSI (select bit, not stored) SHALL pick the next state: 0 -> WRITE; 1 -> READ_ADD if rd_addr_done=0, else READ_DATA.
REQ-014 In WRITE/READ_ADD/READ_DATA, the next 10 MOSI bits SHALL shift into rx_data MSB first, counted by a 4-bit counter 0..9.
REQ-015 rx_valid SHALL be 1 for exactly the one cycle after the 10th bit is sampled; rx_data SHALL hold stable until the next frame's first shift.
REQ-016 On a READ_ADD rx_valid, rd_addr_done SHALL be set; on a READ_DATA rx_valid, it SHALL be cleared.
REQ-017 After its rx_valid, READ_DATA SHALL wait for tx_valid=1, capture tx_data that cycle, then drive MISO with bits 7..0 on the next 8 cycles, then MISO=0.
REQ-018 MISO SHALL be 0 whenever not serializing.
REQ-019 tx_valid outside READ_DATA post-rx_valid wait SHALL be ignored.
REQ-020 SS_n=1 in any state SHALL force IDLE next cycle: partial frame discarded, no rx_valid, serialization aborted, MISO=0; rd_addr_done unchanged.
REQ-021 Command bits rx_data[9:8] SHALL be forwarded unmodified; no decode or rejection in this block.
REQ-022 Back-to-back frames SHALL need SS_n high for at least one cycle between them.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, counters=0, rx_data=0, rx_valid=0, MISO=0, rd_addr_done=0, captured tx byte=0.
REQ-024 Reset release mid-frame SHALL begin in IDLE; the frame resumes only after a new SS_n falling sequence.

Configuration
REQ-025 Macro SPI_RD_ORDER_EN: defined -> rd_addr_done ordering per REQ-013/016 is enforced.
REQ-026 Not defined -> rd_addr_done is absent; select bit 1 always enters READ_DATA, which serializes only if received rx_data[9:8]=2'b11, otherwise returns to waiting for SS_n high without MISO activity.

Structure
REQ-027 Package spi_pkg SHALL hold the state enum, RX_W=10, TX_W=8 and counter width.
REQ-028 One sub-module spi_tx_serializer (load on tx_valid, 8-bit MSB-first shift, busy flag) is natural; the rest stays in spi_slave.

Verification
REQ-029 Write address: SS_n low, MOSI 0 then 00_0000_0101 -> rx_data=10'h005, rx_valid one cycle after bit 10.
REQ-030 Write data: select 0 then 01_1010_1010 -> rx_data=10'h1AA, rx_valid one cycle.
REQ-031 Read sequence: select 1 + 10_0000_0101 (rd_addr_done 0->1), new frame select 1 + 11_0000_0000, tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1, rd_addr_done=0.
REQ-032 Abort: SS_n high after 5 bits of a write -> IDLE next cycle, no rx_valid, rx_data unchanged.
REQ-033 Async reset asserted during MISO shifting -> MISO=0, rx_valid=0, state IDLE without a clock edge.
REQ-034 tx_valid pulsed during a WRITE frame -> no MISO activity.
